pyramid_sequencer: RTL and testbench

- Top-level scheduler for the scale-space pyramid.
- For each octave it runs the Gaussian blur engine NUM_SCALES times, then runs the half-size resize engine, except after the last octave.
- It arbitrates the single shared source-BRAM read port between the blur engine and the resize engine, and reports progress and errors.

---
 rtl/pyramid_pkg.sv | 26 ++
 rtl/seq_watchdog.sv | 29 ++
 rtl/pyramid_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pyramid_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyramid_pkg.sv
// Shared types and helpers for the scale-space pyramid sequencer.
// Holds the FSM state encoding, index widths and the octave-size helper.
package pyramid_pkg;

    localparam int OCT_W = 2;
    localparam int SCL_W = 3;
    localparam int DIM_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        BLUR_START,
        BLUR_WAIT,
        RESIZE_START,
        RESIZE_WAIT,
        DONE,
        ERROR
    } seq_state_t;

    function automatic logic [DIM_W-1:0] octave_dim(
        input logic [DIM_W-1:0] base,
        input logic [OCT_W-1:0] octave
    );
        return base >> octave;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES cycles have been spent waiting.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    // Holds at the terminal value so expiry stays visible until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pyramid_sequencer.sv
// Pyramid build scheduler: sequences blur/resize engines per octave,
// arbitrates the shared source-BRAM read port and reports progress.
module pyramid_sequencer
    import pyramid_pkg::*;
#(
    parameter int BIT_DEPTH      = 8,
    parameter int WIDTH          = 64,
    parameter int HEIGHT         = 64,
    parameter int NUM_OCTAVES    = 3,
    parameter int NUM_SCALES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              error_out,
    output logic [OCT_W-1:0]                  octave_out,
    output logic [SCL_W-1:0]                  scale_out,
    output logic [$clog2(WIDTH):0]            octave_width_out,
    output logic [$clog2(HEIGHT):0]           octave_height_out,
    output logic                              blur_start_out,
    input  logic                              blur_done_in,
    output logic                              resize_start_out,
    input  logic                              resize_done_in,
    input  logic [$clog2(WIDTH*HEIGHT)-1:0]   blur_read_addr_in,
    input  logic                              blur_read_valid_in,
    input  logic [$clog2(WIDTH*HEIGHT)-1:0]   resize_read_addr_in,
    input  logic                              resize_read_valid_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   bram_read_addr_out,
    output logic                              bram_read_valid_out
);

    localparam int WW = $clog2(WIDTH) + 1;
    localparam int HW = $clog2(HEIGHT) + 1;
    localparam logic [OCT_W-1:0] LAST_OCT = OCT_W'(NUM_OCTAVES - 1);
    localparam logic [SCL_W-1:0] LAST_SCL = SCL_W'(NUM_SCALES - 1);

    if (BIT_DEPTH < 1 || NUM_OCTAVES < 1 || NUM_OCTAVES > 4 ||
        NUM_SCALES < 1 || NUM_SCALES > 8) begin : g_bad_params
        $error("pyramid_sequencer: parameter out of range");
    end

    seq_state_t       state;
    logic             start_accept;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;
    logic [OCT_W-1:0] next_oct;

    assign start_accept = start_in && (state == IDLE || state == ERROR);
    assign wd_clear  = start_accept || state == BLUR_START ||
                       state == RESIZE_START;
    assign wd_enable = (state == BLUR_WAIT) || (state == RESIZE_WAIT);
    assign next_oct  = octave_out + OCT_W'(1);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk_in),
        .rst     (rst_in),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            error_out         <= 1'b0;
            octave_out        <= '0;
            scale_out         <= '0;
            octave_width_out  <= WW'(WIDTH);
            octave_height_out <= HW'(HEIGHT);
            blur_start_out    <= 1'b0;
            resize_start_out  <= 1'b0;
        end else begin
            blur_start_out   <= 1'b0;
            resize_start_out <= 1'b0;
            done_out         <= 1'b0;
            unique case (state)
                IDLE, ERROR: begin
                    if (start_in) begin
                        state             <= BLUR_START;
                        busy_out          <= 1'b1;
                        error_out         <= 1'b0;
                        octave_out        <= '0;
                        scale_out         <= '0;
                        octave_width_out  <= WW'(WIDTH);
                        octave_height_out <= HW'(HEIGHT);
                        blur_start_out    <= 1'b1;
                    end
                end
                BLUR_START: state <= BLUR_WAIT;
                BLUR_WAIT: begin
                    // A done in the expiry cycle still counts as success.
                    if (blur_done_in) begin
                        if (scale_out < LAST_SCL) begin
                            scale_out      <= scale_out + SCL_W'(1);
                            state          <= BLUR_START;
                            blur_start_out <= 1'b1;
                        end else if (octave_out < LAST_OCT) begin
                            state            <= RESIZE_START;
                            resize_start_out <= 1'b1;
                        end else begin
                            state    <= DONE;
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        state     <= ERROR;
                        error_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end
                end
                RESIZE_START: state <= RESIZE_WAIT;
                RESIZE_WAIT: begin
                    if (resize_done_in) begin
                        octave_out        <= next_oct;
                        scale_out         <= '0;
                        octave_width_out  <= WW'(octave_dim(DIM_W'(WIDTH), next_oct));
                        octave_height_out <= HW'(octave_dim(DIM_W'(HEIGHT), next_oct));
                        state             <= BLUR_START;
                        blur_start_out    <= 1'b1;
                    end else if (wd_expired) begin
                        state     <= ERROR;
                        error_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The engine not owning the port loses its request outright.
    always_comb begin
        bram_read_addr_out  = '0;
        bram_read_valid_out = 1'b0;
        case (state)
            BLUR_START, BLUR_WAIT: begin
                bram_read_addr_out  = blur_read_addr_in;
                bram_read_valid_out = blur_read_valid_in;
            end
            RESIZE_START, RESIZE_WAIT: begin
                bram_read_addr_out  = resize_read_addr_in;
                bram_read_valid_out = resize_read_valid_in;
            end
            default: begin
                bram_read_addr_out  = '0;
                bram_read_valid_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pyramid_sequencer.sv
// Directed testbench for pyramid_sequencer with simple engine models.
// Inputs and checks happen on the falling clock edge.
module tb_pyramid_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, error;
    logic [1:0]  octave;
    logic [2:0]  scale;
    logic [6:0]  owidth, oheight;
    logic        blur_start, resize_start;
    logic        blur_done_m, blur_done_t, resize_done_m, resize_done_t;
    logic        blur_done, resize_done;
    logic [11:0] blur_addr, resize_addr, bram_addr;
    logic        blur_valid, resize_valid, bram_valid;

    int checks = 0;
    int failures = 0;

    bit auto_en = 1'b0;
    int bcd = -1;
    int rcd = -1;
    int n_blur = 0;
    int n_resize = 0;
    int n_done = 0;
    int wlog[$];

    always #5 clk = ~clk;

    assign blur_done   = blur_done_m | blur_done_t;
    assign resize_done = resize_done_m | resize_done_t;

    pyramid_sequencer #(
        .BIT_DEPTH(8), .WIDTH(64), .HEIGHT(64),
        .NUM_OCTAVES(3), .NUM_SCALES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .start_in             (start),
        .busy_out             (busy),
        .done_out             (done),
        .error_out            (error),
        .octave_out           (octave),
        .scale_out            (scale),
        .octave_width_out     (owidth),
        .octave_height_out    (oheight),
        .blur_start_out       (blur_start),
        .blur_done_in         (blur_done),
        .resize_start_out     (resize_start),
        .resize_done_in       (resize_done),
        .blur_read_addr_in    (blur_addr),
        .blur_read_valid_in   (blur_valid),
        .resize_read_addr_in  (resize_addr),
        .resize_read_valid_in (resize_valid),
        .bram_read_addr_out   (bram_addr),
        .bram_read_valid_out  (bram_valid)
    );

    // Engine models answer 20 cycles after each start when auto_en is set.
    initial begin
        blur_done_m   = 1'b0;
        resize_done_m = 1'b0;
        forever begin
            @(negedge clk);
            blur_done_m   = 1'b0;
            resize_done_m = 1'b0;
            if (bcd > 0) bcd--;
            if (bcd == 0) begin
                blur_done_m = 1'b1;
                bcd = -1;
            end
            if (rcd > 0) rcd--;
            if (rcd == 0) begin
                resize_done_m = 1'b1;
                rcd = -1;
            end
            if (blur_start) begin
                n_blur++;
                if (scale == 3'd0) wlog.push_back(int'(owidth));
                if (auto_en) bcd = 20;
            end
            if (resize_start) begin
                n_resize++;
                if (auto_en) rcd = 20;
            end
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        blur_done_t = 1'b0;
        resize_done_t = 1'b0;
        blur_addr = 12'h123;
        blur_valid = 1'b1;
        resize_addr = 12'h456;
        resize_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_error: got %0b%0b expected 00", done, error);
        end
        checks++;
        if (octave !== 2'd0 || scale !== 3'd0) begin
            failures++;
            $display("FAIL reset_indices: got %0d/%0d expected 0/0", octave, scale);
        end
        checks++;
        if (owidth !== 7'd64 || oheight !== 7'd64) begin
            failures++;
            $display("FAIL reset_dims: got %0d x %0d expected 64 x 64", owidth, oheight);
        end
        checks++;
        if (blur_start !== 1'b0 || resize_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_starts: got %0b%0b expected 00", blur_start, resize_start);
        end
        checks++;
        if (bram_addr !== 12'h000 || bram_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_mux: got %0h/%0b expected 0/0", bram_addr, bram_valid);
        end
    endtask

    task automatic test_full_build();
        bit seen = 1'b0;
        n_blur = 0;
        n_resize = 0;
        n_done = 0;
        wlog.delete();
        auto_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || blur_start !== 1'b1) begin
            failures++;
            $display("FAIL build_launch: got busy=%0b blur_start=%0b expected 1/1", busy, blur_start);
        end
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_busy_drop: got %0b expected 0", busy);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL build_timeout: got no done expected done within 3000 cycles");
        end
        repeat (30) tick();
        auto_en = 1'b0;
        checks++;
        if (n_blur !== 12) begin
            failures++;
            $display("FAIL blur_start_count: got %0d expected 12", n_blur);
        end
        checks++;
        if (n_resize !== 2) begin
            failures++;
            $display("FAIL resize_start_count: got %0d expected 2", n_resize);
        end
        checks++;
        if (n_done !== 1) begin
            failures++;
            $display("FAIL done_count: got %0d expected 1", n_done);
        end
        checks++;
        if (wlog.size() != 3 || wlog[0] != 64 || wlog[1] != 32 || wlog[2] != 16) begin
            failures++;
            $display("FAIL width_sequence: got %p expected 64 32 16", wlog);
        end
        checks++;
        if (owidth !== 7'd16 || oheight !== 7'd16 || busy !== 1'b0) begin
            failures++;
            $display("FAIL build_end_state: got %0d x %0d busy=%0b expected 16 x 16 busy=0",
                     owidth, oheight, busy);
        end
    endtask

    task automatic test_start_timing();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (blur_start !== 1'b1) begin
            failures++;
            $display("FAIL start_to_blur: got %0b expected 1", blur_start);
        end
        tick();
        checks++;
        if (blur_start !== 1'b0 || scale !== 3'd0) begin
            failures++;
            $display("FAIL blur_pulse_width: got %0b scale=%0d expected 0 scale=0", blur_start, scale);
        end
        repeat (4) tick();
        blur_done_t = 1'b1;
        tick();
        blur_done_t = 1'b0;
        checks++;
        if (blur_start !== 1'b1 || scale !== 3'd1) begin
            failures++;
            $display("FAIL done_to_next_blur: got %0b scale=%0d expected 1 scale=1", blur_start, scale);
        end
        tick();
        checks++;
        if (blur_start !== 1'b0) begin
            failures++;
            $display("FAIL next_blur_width: got %0b expected 0", blur_start);
        end
    endtask

    task automatic test_stray_inputs();
        int nb;
        int nr;
        tick();
        nb = n_blur;
        nr = n_resize;
        resize_done_t = 1'b1;
        tick();
        resize_done_t = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (scale !== 3'd1 || octave !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stray_state: got oct=%0d scale=%0d busy=%0b expected 0/1/1",
                     octave, scale, busy);
        end
        checks++;
        if (n_blur != nb || n_resize != nr) begin
            failures++;
            $display("FAIL stray_counts: got %0d/%0d expected %0d/%0d", n_blur, n_resize, nb, nr);
        end
        checks++;
        if (bram_addr !== 12'h123 || bram_valid !== 1'b1) begin
            failures++;
            $display("FAIL blur_mux: got %0h/%0b expected 123/1", bram_addr, bram_valid);
        end
    endtask

    task automatic test_read_mux();
        for (int i = 0; i < 2; i++) begin
            blur_done_t = 1'b1;
            tick();
            blur_done_t = 1'b0;
            repeat (2) tick();
        end
        blur_done_t = 1'b1;
        tick();
        blur_done_t = 1'b0;
        checks++;
        if (resize_start !== 1'b1 || bram_addr !== 12'h456) begin
            failures++;
            $display("FAIL resize_launch: got %0b addr=%0h expected 1 addr=456", resize_start, bram_addr);
        end
        tick();
        checks++;
        if (resize_start !== 1'b0 || bram_addr !== 12'h456 || bram_valid !== 1'b1) begin
            failures++;
            $display("FAIL resize_mux: got %0b %0h/%0b expected 0 456/1",
                     resize_start, bram_addr, bram_valid);
        end
        blur_done_t = 1'b1;
        tick();
        blur_done_t = 1'b0;
        tick();
        checks++;
        if (octave !== 2'd0 || blur_start !== 1'b0 || busy !== 1'b1 || bram_addr !== 12'h456) begin
            failures++;
            $display("FAIL stray_blur_done: got oct=%0d bs=%0b busy=%0b addr=%0h expected 0/0/1/456",
                     octave, blur_start, busy, bram_addr);
        end
        resize_valid = 1'b0;
        #1;
        checks++;
        if (bram_valid !== 1'b0) begin
            failures++;
            $display("FAIL resize_valid_pass: got %0b expected 0", bram_valid);
        end
        resize_valid = 1'b1;
    endtask

    task automatic test_reset_mid();
        int nb;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || octave !== 2'd0 || scale !== 3'd0 ||
            owidth !== 7'd64 || oheight !== 7'd64) begin
            failures++;
            $display("FAIL mid_reset_state: got busy=%0b oct=%0d scale=%0d %0dx%0d expected 0/0/0 64x64",
                     busy, octave, scale, owidth, oheight);
        end
        checks++;
        if (bram_valid !== 1'b0 || bram_addr !== 12'h000 || resize_start !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_mux: got %0h/%0b rs=%0b expected 0/0 rs=0",
                     bram_addr, bram_valid, resize_start);
        end
        rst = 1'b0;
        resize_done_t = 1'b1;
        tick();
        resize_done_t = 1'b0;
        nb = n_blur;
        repeat (30) tick();
        checks++;
        if (n_blur != nb || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet: got blur starts +%0d busy=%0b expected +0 busy=0",
                     n_blur - nb, busy);
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got err=%0b busy=%0b expected 0/1", error, busy);
        end
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_error: got err=%0b busy=%0b expected 1/0", error, busy);
        end
        repeat (10) tick();
        checks++;
        if (error !== 1'b1 || blur_start !== 1'b0) begin
            failures++;
            $display("FAIL error_sticky: got err=%0b bs=%0b expected 1/0", error, blur_start);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || blur_start !== 1'b1 ||
            octave !== 2'd0 || scale !== 3'd0) begin
            failures++;
            $display("FAIL error_restart: got err=%0b busy=%0b bs=%0b oct=%0d scale=%0d expected 0/1/1/0/0",
                     error, busy, blur_start, octave, scale);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_build();
        test_start_timing();
        test_stray_inputs();
        test_read_mux();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
